ball_link_scheduler: RTL and testbench
======================================

Name: ball_link_scheduler

Overview:
Sequences transmission of the ball hand-off frame to the opposite board over the shared I2C byte engine. It captures ball state when the game controller raises its send trigger, then issues the frame to the engine byte by byte under a valid/ready handshake. It supervises per-byte ACK and timeout, retries the whole frame with back-off, and returns a single completion pulse to the game controller. It sits between the game controller and the I2C master byte engine on the left-player board.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit I2C address of the peer board.
BYTE_TIMEOUT, 25000, cycles allowed from cmd accept to byte_done (1 ms at 25 MHz).
MAX_RETRY, 3, frame re-attempts after the first failure.
BACKOFF_CYCLES, 2500, idle cycles between abort and retry.

Ports:
clk_25MHZ  input  1  system clock
reset  input  1  asynchronous, active-high reset
ball_send_trigger  input  1  level from game controller; rising edge requests a send
ball_y  input  10  ball y position
ball_vy  input  8  signed y velocity
gravity_counter  input  2  gravity phase
ball_speed_sel  input  1  1 = slow (270000), 0 = fast (135000)
cmd_valid  output  1  byte command valid to engine
cmd_ready  input  1  engine accepts command
cmd_data  output  8  byte to send
cmd_addr  output  7  slave address (constant SLAVE_ADDR)
cmd_start  output  1  this byte is preceded by START+address
cmd_stop  output  1  STOP follows this byte
cmd_abort  output  1  one-cycle pulse; engine issues STOP immediately
byte_done  input  1  one-cycle pulse; byte finished
byte_nack  input  1  qualifies byte_done; peer NACKed
is_i2c_master_done  output  1  one-cycle pulse; frame finished (success or failure)
link_error  output  1  sticky; set when retries are exhausted, cleared by the next trigger edge
busy  output  1  high in every state except IDLE
retry_count  output  2  attempts used in the current frame

Behaviour:
- Reset values: all outputs 0 except cmd_addr = SLAVE_ADDR. State returns to IDLE. Reset mid-frame takes effect immediately and does not pulse cmd_abort.
- Frame bytes, in order:
  - F0 = 8'h00 (register pointer)
  - F1 = {ball_y[9:8], 6'b0}
  - F2 = ball_y[7:0]
  - F3 = ball_vy
  - F4 = {6'b0, gravity_counter}
  - F5 = {7'b0, ball_speed_sel}
- Snapshot: frame contents are captured once, in LATCH. Input changes afterwards are ignored until the next frame.
- States and transitions:
  - IDLE -> LATCH on a rising edge of ball_send_trigger (edge register reset to 0). The same edge clears link_error and retry_count.
  - LATCH (1 cycle) -> SEND with byte index 0.
  - SEND: cmd_valid = 1; cmd_data = F[idx]; cmd_start = (idx == 0); cmd_stop = (idx == last).
    - On cmd_valid && cmd_ready -> WAIT. The timeout counter is cleared.
    - cmd_* outputs stay stable while valid is high and ready is low.
  - WAIT: the timeout counter increments each cycle.
    - byte_done && !byte_nack: if idx == last -> DONE, else idx+1 -> SEND.
    - byte_done && byte_nack, or counter reaches BYTE_TIMEOUT-1: pulse cmd_abort and go to BACKOFF.
    - If byte_done and timeout occur in the same cycle, byte_done wins.
  - BACKOFF: counts BACKOFF_CYCLES.
    - If retry_count < MAX_RETRY: retry_count+1, idx = 0 -> SEND. The snapshot is reused.
    - Otherwise: set link_error -> DONE.
  - DONE: pulse is_i2c_master_done for 1 cycle -> IDLE.
- Latency and throughput:
  - Trigger edge sampled in cycle N -> LATCH in N+1 -> first cmd_valid in N+2.
  - Minimum one cycle from byte_done to the next cmd_valid.
- Trigger edges while busy are ignored; no queueing.
- Counters: the timeout counter is sized to fit BYTE_TIMEOUT; retry_count saturates at MAX_RETRY.

Optional Feature:
BALL_LINK_CHECKSUM_EN
- Defined: a sixth data byte F6 = F1^F2^F3^F4^F5 is appended; last index = 6 and cmd_stop is on F6.
- Undefined: last index = 5 and no checksum logic is synthesized.

Decomposition:
- Package ball_link_pkg holds:
  - state enum link_state_t
  - FRAME_LEN_BASE = 6
  - REG_PTR = 8'h00
  - frame byte index constants
- One sub-module, ball_frame_packer: combinational mux of snapshot registers plus index to cmd_data, with the optional checksum.
- The FSM, counters and handshake logic stay in the top module.

Test Plan:
- Nominal send: ball_y = 10'h2A5, vy = -3, gravity = 2, speed_sel = 1, engine always ready, all ACKs -> bytes 00, 80, A5, FD, 02, 01; cmd_start on byte 0 only, cmd_stop on byte 5 only. One is_i2c_master_done pulse, link_error = 0.
- Backpressure: cmd_ready held low for 7 cycles on byte 2 -> cmd_data stays A5 and cmd_valid stays high; the byte is accepted on the first ready cycle.
- NACK on byte 3 of the first attempt, then all ACKs -> cmd_abort pulse, a BACKOFF of 2500 cycles, then the full frame resent from byte 0. retry_count = 1, done pulse, no error.
- Persistent timeout (byte_done never arrives) -> 4 attempts, each aborting 25000 cycles after accept. link_error = 1 and one done pulse; retry_count = 3.
- Trigger re-assertion and inputs changed mid-frame -> no restart; bytes match the snapshot. Reset asserted in WAIT -> all outputs 0 in the same cycle.
- With BALL_LINK_CHECKSUM_EN and the nominal vector -> 7th byte DB carries cmd_stop.

Source files
------------

// File: rtl/ball_link_pkg.sv
// Shared types and frame constants for the ball hand-off link scheduler.
// BALL_LINK_CHECKSUM_EN appends an XOR checksum byte to the frame.
package ball_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_SEND,
      ST_WAIT,
      ST_BACKOFF,
      ST_DONE
   } link_state_t;

   localparam int unsigned FRAME_LEN_BASE = 6;
`ifdef BALL_LINK_CHECKSUM_EN
   localparam int unsigned FRAME_LEN = FRAME_LEN_BASE + 1;
`else
   localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

   localparam int unsigned IDX_W = 3;
   localparam logic [7:0] REG_PTR = 8'h00;

   localparam logic [IDX_W-1:0] IDX_REG_PTR = 3'd0;
   localparam logic [IDX_W-1:0] IDX_Y_HI    = 3'd1;
   localparam logic [IDX_W-1:0] IDX_Y_LO    = 3'd2;
   localparam logic [IDX_W-1:0] IDX_VY      = 3'd3;
   localparam logic [IDX_W-1:0] IDX_GRAV    = 3'd4;
   localparam logic [IDX_W-1:0] IDX_SPEED   = 3'd5;
   localparam logic [IDX_W-1:0] IDX_CSUM    = 3'd6;
   localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_LEN - 1);

   // Ball state captured once per frame and reused across retries.
   typedef struct packed {
      logic [9:0] y;
      logic [7:0] vy;
      logic [1:0] gravity;
      logic       speed_sel;
   } ball_snap_t;

endpackage

// File: rtl/ball_frame_packer.sv
// Selects the frame byte for a given index from the ball snapshot.
// BALL_LINK_CHECKSUM_EN adds the XOR checksum byte at the last index.
module ball_frame_packer
   import ball_link_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   input  ball_snap_t       snap,
   output logic [7:0]       byte_c
);

   logic [7:0] y_hi_c;
   logic [7:0] y_lo_c;
   logic [7:0] grav_c;
   logic [7:0] speed_c;

   assign y_hi_c  = {snap.y[9:8], 6'b0};
   assign y_lo_c  = snap.y[7:0];
   assign grav_c  = {6'b0, snap.gravity};
   assign speed_c = {7'b0, snap.speed_sel};

`ifdef BALL_LINK_CHECKSUM_EN
   logic [7:0] csum_c;
   assign csum_c = y_hi_c ^ y_lo_c ^ snap.vy ^ grav_c ^ speed_c;
`endif

   always_comb begin
      byte_c = REG_PTR;
      case (idx)
         IDX_Y_HI:  byte_c = y_hi_c;
         IDX_Y_LO:  byte_c = y_lo_c;
         IDX_VY:    byte_c = snap.vy;
         IDX_GRAV:  byte_c = grav_c;
         IDX_SPEED: byte_c = speed_c;
`ifdef BALL_LINK_CHECKSUM_EN
         IDX_CSUM:  byte_c = csum_c;
`endif
         default:   byte_c = REG_PTR;
      endcase
   end

endmodule

// File: rtl/ball_link_scheduler.sv
// Sends the ball hand-off frame over the I2C byte engine with ACK/timeout
// supervision and whole-frame retries. BALL_LINK_CHECKSUM_EN adds a checksum byte.
module ball_link_scheduler
   import ball_link_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR     = 7'h42,
   parameter int unsigned BYTE_TIMEOUT   = 25000,
   parameter int unsigned MAX_RETRY      = 3,
   parameter int unsigned BACKOFF_CYCLES = 2500
) (
   input  logic       clk_25MHZ,
   input  logic       reset,
   input  logic       ball_send_trigger,
   input  logic [9:0] ball_y,
   input  logic [7:0] ball_vy,
   input  logic [1:0] gravity_counter,
   input  logic       ball_speed_sel,
   output logic       cmd_valid,
   input  logic       cmd_ready,
   output logic [7:0] cmd_data,
   output logic [6:0] cmd_addr,
   output logic       cmd_start,
   output logic       cmd_stop,
   output logic       cmd_abort,
   input  logic       byte_done,
   input  logic       byte_nack,
   output logic       is_i2c_master_done,
   output logic       link_error,
   output logic       busy,
   output logic [1:0] retry_count
);

   localparam int unsigned TMO_W   = $clog2(BYTE_TIMEOUT + 1);
   localparam int unsigned BOFF_W  = $clog2(BACKOFF_CYCLES + 1);
   localparam int unsigned RETRY_W = 2;

   link_state_t        state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [BOFF_W-1:0]  boff_q, boff_d;
   logic [RETRY_W-1:0] retry_d;
   logic               link_error_d;
   logic               trig_q;
   logic               trig_rise;
   ball_snap_t         snap_q, snap_d;
   logic [7:0]         frame_byte_c;

   logic       cmd_valid_d, cmd_start_d, cmd_stop_d, cmd_abort_d;
   logic       done_d, busy_d;
   logic [7:0] cmd_data_d;

   assign cmd_addr  = SLAVE_ADDR;
   assign trig_rise = ball_send_trigger & ~trig_q;

   // Packer looks at next-cycle index/snapshot so cmd_data can be registered.
   ball_frame_packer u_packer (
      .idx    (idx_d),
      .snap   (snap_d),
      .byte_c (frame_byte_c)
   );

   // State, counters and registered outputs.
   always_ff @(posedge clk_25MHZ or posedge reset) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         idx_q              <= '0;
         tmo_q              <= '0;
         boff_q             <= '0;
         retry_count        <= '0;
         link_error         <= 1'b0;
         trig_q             <= 1'b0;
         snap_q             <= '0;
         cmd_valid          <= 1'b0;
         cmd_data           <= '0;
         cmd_start          <= 1'b0;
         cmd_stop           <= 1'b0;
         cmd_abort          <= 1'b0;
         is_i2c_master_done <= 1'b0;
         busy               <= 1'b0;
      end else begin
         state_q            <= state_d;
         idx_q              <= idx_d;
         tmo_q              <= tmo_d;
         boff_q             <= boff_d;
         retry_count        <= retry_d;
         link_error         <= link_error_d;
         trig_q             <= ball_send_trigger;
         snap_q             <= snap_d;
         cmd_valid          <= cmd_valid_d;
         cmd_data           <= cmd_data_d;
         cmd_start          <= cmd_start_d;
         cmd_stop           <= cmd_stop_d;
         cmd_abort          <= cmd_abort_d;
         is_i2c_master_done <= done_d;
         busy               <= busy_d;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      boff_d       = boff_q;
      retry_d      = retry_count;
      link_error_d = link_error;
      snap_d       = snap_q;
      case (state_q)
         ST_IDLE: begin
            if (trig_rise) begin
               retry_d      = '0;
               link_error_d = 1'b0;
               state_d      = ST_LATCH;
            end
         end
         ST_LATCH: begin
            snap_d.y         = ball_y;
            snap_d.vy        = ball_vy;
            snap_d.gravity   = gravity_counter;
            snap_d.speed_sel = ball_speed_sel;
            idx_d            = '0;
            state_d          = ST_SEND;
         end
         ST_SEND: begin
            if (cmd_valid && cmd_ready) begin
               tmo_d   = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            // A good byte_done beats a timeout landing in the same cycle.
            if (byte_done && !byte_nack) begin
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_SEND;
               end
            end else if (byte_done || (tmo_q == TMO_W'(BYTE_TIMEOUT - 1))) begin
               boff_d  = '0;
               state_d = ST_BACKOFF;
            end
         end
         ST_BACKOFF: begin
            boff_d = boff_q + 1'b1;
            if (boff_q == BOFF_W'(BACKOFF_CYCLES - 1)) begin
               if (retry_count < RETRY_W'(MAX_RETRY)) begin
                  retry_d = retry_count + 1'b1;
                  idx_d   = '0;
                  state_d = ST_SEND;
               end else begin
                  link_error_d = 1'b1;
                  state_d      = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state; registered above.
   always_comb begin
      cmd_valid_d = (state_d == ST_SEND);
      cmd_data_d  = cmd_valid_d ? frame_byte_c : 8'h00;
      cmd_start_d = cmd_valid_d && (idx_d == IDX_REG_PTR);
      cmd_stop_d  = cmd_valid_d && (idx_d == IDX_LAST);
      cmd_abort_d = (state_q == ST_WAIT) && (state_d == ST_BACKOFF);
      done_d      = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

endmodule

// File: tb/tb_ball_link_scheduler.sv
// Self-checking bench for ball_link_scheduler: bench acts as the I2C engine and
// checks every byte, abort, back-off and completion against a frame model.
module tb_ball_link_scheduler;

   localparam int T = 40;
   localparam int B = 20;
   localparam int R = 3;
`ifdef BALL_LINK_CHECKSUM_EN
   localparam int LAST = 6;
`else
   localparam int LAST = 5;
`endif

   logic       clk_25MHZ = 1'b0;
   logic       reset;
   logic       ball_send_trigger;
   logic [9:0] ball_y;
   logic [7:0] ball_vy;
   logic [1:0] gravity_counter;
   logic       ball_speed_sel;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_data;
   logic [6:0] cmd_addr;
   logic       cmd_start;
   logic       cmd_stop;
   logic       cmd_abort;
   logic       byte_done;
   logic       byte_nack;
   logic       is_i2c_master_done;
   logic       link_error;
   logic       busy;
   logic [1:0] retry_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_frame [0:6];

   always #20 clk_25MHZ = ~clk_25MHZ;

   ball_link_scheduler #(
      .SLAVE_ADDR     (7'h42),
      .BYTE_TIMEOUT   (T),
      .MAX_RETRY      (R),
      .BACKOFF_CYCLES (B)
   ) dut (
      .clk_25MHZ          (clk_25MHZ),
      .reset              (reset),
      .ball_send_trigger  (ball_send_trigger),
      .ball_y             (ball_y),
      .ball_vy            (ball_vy),
      .gravity_counter    (gravity_counter),
      .ball_speed_sel     (ball_speed_sel),
      .cmd_valid          (cmd_valid),
      .cmd_ready          (cmd_ready),
      .cmd_data           (cmd_data),
      .cmd_addr           (cmd_addr),
      .cmd_start          (cmd_start),
      .cmd_stop           (cmd_stop),
      .cmd_abort          (cmd_abort),
      .byte_done          (byte_done),
      .byte_nack          (byte_nack),
      .is_i2c_master_done (is_i2c_master_done),
      .link_error         (link_error),
      .busy               (busy),
      .retry_count        (retry_count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, want);
      end
   endtask

   // Frame model built from the field layout with plain arithmetic.
   task automatic build_frame(input logic [9:0] y, input logic [7:0] vy,
                              input logic [1:0] g, input logic s);
      exp_frame[0] = 8'h00;
      exp_frame[1] = 8'((int'(y) / 256) * 64);
      exp_frame[2] = 8'(int'(y) % 256);
      exp_frame[3] = vy;
      exp_frame[4] = 8'(g);
      exp_frame[5] = 8'(s);
      exp_frame[6] = exp_frame[1] ^ exp_frame[2] ^ exp_frame[3] ^ exp_frame[4] ^ exp_frame[5];
   endtask

   task automatic wait_valid(output int cyc, output bit ok);
      cyc = 0;
      while (!cmd_valid && cyc < T + B + 10) begin
         @(negedge clk_25MHZ);
         cyc++;
      end
      ok = cmd_valid;
   endtask

   task automatic end_frame();
      ball_send_trigger = 1'b0;
      cmd_ready = 1'b0;
      byte_done = 1'b0;
      byte_nack = 1'b0;
      repeat (2) @(negedge clk_25MHZ);
   endtask

   // One frame: 'fails' attempts fail on fail_byte (NACK or timeout), optional
   // stall on stall_byte of attempt 0, byte_done at the timeout boundary on slow_byte.
   task automatic do_frame(input int fails, input bit use_nack, input int fail_byte,
                           input int stall_byte, input int stall_len, input int slow_byte,
                           input logic [9:0] y, input logic [7:0] vy,
                           input logic [1:0] g, input logic s);
      int  attempt;
      int  cyc;
      int  d;
      bit  ok;
      bit  finished;
      ball_y = y; ball_vy = vy; gravity_counter = g; ball_speed_sel = s;
      build_frame(y, vy, g, s);
      @(negedge clk_25MHZ);
      ball_send_trigger = 1'b1;
      @(negedge clk_25MHZ);
      check_val("latch_busy", busy, 1);
      check_val("latch_valid", cmd_valid, 0);
      check_val("err_cleared", link_error, 0);
      check_val("retry_cleared", retry_count, 0);
      @(negedge clk_25MHZ);
      check_val("first_valid_latency", cmd_valid, 1);
      // Inputs move after the snapshot; frame must not follow them.
      ball_send_trigger = 1'b0;
      ball_y = 10'($urandom); ball_vy = 8'($urandom);
      gravity_counter = 2'($urandom); ball_speed_sel = 1'($urandom);
      attempt = 0;
      finished = 1'b0;
      while (!finished) begin
         for (int i = 0; i <= LAST; i++) begin
            wait_valid(cyc, ok);
            check_val("valid_seen", 32'(ok), 1);
            if (!ok) begin
               end_frame();
               return;
            end
            check_val("cmd_data", cmd_data, exp_frame[i]);
            check_val("cmd_start", cmd_start, (i == 0) ? 1 : 0);
            check_val("cmd_stop", cmd_stop, (i == LAST) ? 1 : 0);
            if (i == 1) ball_send_trigger = 1'b1;
            if (attempt == 0 && i == stall_byte) begin
               repeat (stall_len) begin
                  @(negedge clk_25MHZ);
                  check_val("stall_valid", cmd_valid, 1);
                  check_val("stall_data", cmd_data, exp_frame[i]);
               end
            end
            cmd_ready = 1'b1;
            @(negedge clk_25MHZ);
            cmd_ready = 1'b0;
            check_val("accepted", cmd_valid, 0);
            if (attempt < fails && i == fail_byte) begin
               if (use_nack) begin
                  d = $urandom_range(0, 5);
                  repeat (d) @(negedge clk_25MHZ);
                  byte_done = 1'b1; byte_nack = 1'b1;
                  @(negedge clk_25MHZ);
                  byte_done = 1'b0; byte_nack = 1'b0;
                  check_val("nack_abort", cmd_abort, 1);
               end else begin
                  cyc = 0;
                  while (!cmd_abort && cyc < T + 5) begin
                     @(negedge clk_25MHZ);
                     cyc++;
                  end
                  check_val("timeout_len", cyc, T);
               end
               if (attempt < R) begin
                  @(negedge clk_25MHZ);
                  check_val("abort_pulse", cmd_abort, 0);
                  wait_valid(cyc, ok);
                  check_val("backoff_len", cyc, B - 1);
                  attempt++;
                  check_val("retry_count", retry_count, attempt);
               end else begin
                  cyc = 0;
                  while (!is_i2c_master_done && cyc < B + 5) begin
                     @(negedge clk_25MHZ);
                     cyc++;
                  end
                  check_val("err_done_delay", cyc, B);
                  finished = 1'b1;
               end
               break;
            end else begin
               d = (i == slow_byte) ? T - 1 : $urandom_range(0, 3);
               repeat (d) @(negedge clk_25MHZ);
               byte_done = 1'b1;
               @(negedge clk_25MHZ);
               byte_done = 1'b0;
               if (i == LAST) begin
                  check_val("done_pulse", is_i2c_master_done, 1);
                  finished = 1'b1;
               end else begin
                  check_val("next_valid", cmd_valid, 1);
               end
            end
         end
      end
      check_val("final_error", link_error, (fails > R) ? 1 : 0);
      check_val("final_retry", retry_count, (fails > R) ? R : fails);
      @(negedge clk_25MHZ);
      check_val("done_single", is_i2c_master_done, 0);
      check_val("idle_busy", busy, 0);
      end_frame();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, cmd_valid, 0);
      check_val({tag, "_data"}, cmd_data, 0);
      check_val({tag, "_start"}, cmd_start, 0);
      check_val({tag, "_stop"}, cmd_stop, 0);
      check_val({tag, "_abort"}, cmd_abort, 0);
      check_val({tag, "_done"}, is_i2c_master_done, 0);
      check_val({tag, "_err"}, link_error, 0);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_retry"}, retry_count, 0);
      check_val({tag, "_addr"}, cmd_addr, 7'h42);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ball_send_trigger = 1'b0;
      ball_y = '0; ball_vy = '0; gravity_counter = '0; ball_speed_sel = 1'b0;
      cmd_ready = 1'b0; byte_done = 1'b0; byte_nack = 1'b0;
      repeat (3) @(negedge clk_25MHZ);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk_25MHZ);
      check_all_zero("idle");

      // Nominal vector: 00 80 A5 FD 02 01 (DB checksum when enabled).
      do_frame(0, 1'b0, 0, -1, 0, -1, 10'h2A5, 8'hFD, 2'd2, 1'b1);
      // Backpressure on byte 2.
      do_frame(0, 1'b0, 0, 2, 7, -1, 10'h2A5, 8'hFD, 2'd2, 1'b1);
      // NACK on byte 3 of the first attempt.
      do_frame(1, 1'b1, 3, -1, 0, -1, 10'h2A5, 8'hFD, 2'd2, 1'b1);
      // Persistent timeout: retries exhausted.
      do_frame(4, 1'b0, 1, -1, 0, -1, 10'h13C, 8'h7F, 2'd1, 1'b0);
      // byte_done in the same cycle as timeout expiry must win.
      do_frame(0, 1'b0, 0, -1, 0, 4, 10'h3FF, 8'h80, 2'd3, 1'b1);

      for (int n = 0; n < 10; n++) begin
         do_frame($urandom_range(0, 4), 1'($urandom), $urandom_range(0, LAST),
                  $urandom_range(0, LAST), $urandom_range(0, 4), $urandom_range(0, LAST + 4),
                  10'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
      end

      // Reset while waiting for byte_done.
      @(negedge clk_25MHZ);
      ball_send_trigger = 1'b1;
      repeat (2) @(negedge clk_25MHZ);
      check_val("rst_pre_valid", cmd_valid, 1);
      cmd_ready = 1'b1;
      @(negedge clk_25MHZ);
      cmd_ready = 1'b0;
      repeat (3) @(negedge clk_25MHZ);
      check_val("rst_pre_busy", busy, 1);
      reset = 1'b1;
      #1;
      check_all_zero("rst_wait");
      @(negedge clk_25MHZ);
      ball_send_trigger = 1'b0;
      @(negedge clk_25MHZ);
      reset = 1'b0;
      repeat (3) @(negedge clk_25MHZ);
      check_all_zero("post_rst");

      do_frame(0, 1'b0, 0, 0, 2, -1, 10'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
